// File: rtl/fwd_hazard_unit.sv
// Operand forwarding select and load-use hazard stall control.
// Holds the front end LOAD_LAT cycles per load-use hazard and counts stalls.
module fwd_hazard_unit #(
    parameter int NUM_SRC  = 2,
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic [NUM_SRC*REG_AW-1:0]  if_id_rs,
    input  logic [NUM_SRC-1:0]         if_id_rs_used,
    input  logic [NUM_SRC*REG_AW-1:0]  id_ex_rs,
    input  logic [NUM_SRC-1:0]         id_ex_rs_used,
    input  logic [REG_AW-1:0]          id_ex_rd,
    input  logic                       id_ex_mem_read,
    input  logic [REG_AW-1:0]          ex_mem_rd,
    input  logic                       ex_mem_reg_write,
    input  logic [REG_AW-1:0]          mem_wb_rd,
    input  logic                       mem_wb_reg_write,
    output logic [2*NUM_SRC-1:0]       fw,
    output logic                       stall,
    output logic                       bubble,
    output logic [CNT_W-1:0]           stall_cycles,
    output logic [CNT_W-1:0]           lu_events
);

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] lu_events_q, lu_events_d;
    logic             hazard;
    logic             stall_c;
    logic             lu_inc;

    // Per-port forwarding select; EX/MEM wins over MEM/WB, x0 never forwards.
    always_comb begin
        fw = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (id_ex_rs_used[k] && ex_mem_reg_write &&
                (ex_mem_rd != '0) &&
                (ex_mem_rd == id_ex_rs[k*REG_AW +: REG_AW])) begin
                fw[2*k +: 2] = 2'b10;
            end else if (id_ex_rs_used[k] && mem_wb_reg_write &&
                         (mem_wb_rd != '0) &&
                         (mem_wb_rd == id_ex_rs[k*REG_AW +: REG_AW])) begin
                fw[2*k +: 2] = 2'b01;
            end
        end
    end

    // Load in EX whose destination is read by the instruction in ID.
    always_comb begin
        hazard = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (if_id_rs_used[k] &&
                (if_id_rs[k*REG_AW +: REG_AW] == id_ex_rd)) begin
                hazard = 1'b1;
            end
        end
        hazard = hazard && id_ex_mem_read && (id_ex_rd != '0);
    end

    // Stall FSM next state and stall output; flush and reset squash the stall.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall_c = 1'b0;
        lu_inc  = 1'b0;
        unique case (state_q)
            IDLE: begin
                stall_c = hazard && !flush;
                lu_inc  = stall_c;
                if (stall_c && (LOAD_LAT > 1)) begin
                    state_d = HOLD;
                    cnt_d   = 3'(LOAD_LAT - 1);
                end
            end
            HOLD: begin
                stall_c = !flush;
                cnt_d   = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
        if (reset) begin
            stall_c = 1'b0;
            lu_inc  = 1'b0;
        end
    end

    // Saturating performance counter increments.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        lu_events_d    = lu_events_q;
        if (stall_c && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + 1'b1;
        end
        if (lu_inc && (lu_events_q != '1)) begin
            lu_events_d = lu_events_q + 1'b1;
        end
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            stall_cycles_q <= '0;
            lu_events_q    <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            stall_cycles_q <= stall_cycles_d;
            lu_events_q    <= lu_events_d;
        end
    end

    assign stall        = stall_c;
    assign bubble       = stall_c;
    assign stall_cycles = stall_cycles_q;
    assign lu_events    = lu_events_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit.
// Three instances (LOAD_LAT 1, 3, 4) share one stimulus stream.
module tb_fwd_hazard_unit;

    localparam int NS = 3;
    localparam int AW = 5;
    localparam int CW = 4;
    localparam int LL [3] = '{1, 3, 4};

    typedef logic [2:0][CW-1:0] cv_t;

    typedef struct {
        string      nm;
        bit         cf;
        logic [5:0] fw;
        logic [2:0] sm;
        logic [2:0] st;
        logic [2:0] cm;
        cv_t        sc;
        cv_t        lu;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic flush;
    logic [AW-1:0] irs [NS];
    logic [AW-1:0] ers [NS];
    logic [NS-1:0] iused, eused;
    logic [AW-1:0] idrd, mmrd, wbrd;
    logic mr, mw, ww;
    logic [NS*AW-1:0] if_id_rs, id_ex_rs;

    logic [2*NS-1:0] fw [3];
    logic [2:0] st, bb;
    logic [CW-1:0] sc [3];
    logic [CW-1:0] lu [3];

    exp_t sb [$];
    exp_t e;
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < NS; k++) begin
            if_id_rs[k*AW +: AW] = irs[k];
            id_ex_rs[k*AW +: AW] = ers[k];
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_dut
        fwd_hazard_unit #(
            .NUM_SRC (NS),
            .REG_AW  (AW),
            .LOAD_LAT(LL[g]),
            .CNT_W   (CW)
        ) u_dut (
            .clk             (clk),
            .reset           (reset),
            .flush           (flush),
            .if_id_rs        (if_id_rs),
            .if_id_rs_used   (iused),
            .id_ex_rs        (id_ex_rs),
            .id_ex_rs_used   (eused),
            .id_ex_rd        (idrd),
            .id_ex_mem_read  (mr),
            .ex_mem_rd       (mmrd),
            .ex_mem_reg_write(mw),
            .mem_wb_rd       (wbrd),
            .mem_wb_reg_write(ww),
            .fw              (fw[g]),
            .stall           (st[g]),
            .bubble          (bb[g]),
            .stall_cycles    (sc[g]),
            .lu_events       (lu[g])
        );
    end

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exv);
        n_tests++;
        if (act !== exv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exv);
        end
    endtask

    // Monitor: one expected entry per cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.cf) chk({e.nm, " fw"}, 8'(fw[0]), 8'(e.fw));
            for (int g = 0; g < 3; g++) begin
                if (e.sm[g]) begin
                    chk($sformatf("%s stall%0d", e.nm, LL[g]),
                        8'(st[g]), 8'(e.st[g]));
                    chk($sformatf("%s bubble%0d", e.nm, LL[g]),
                        8'(bb[g]), 8'(e.st[g]));
                end
                if (e.cm[g]) begin
                    chk($sformatf("%s stall_cycles%0d", e.nm, LL[g]),
                        8'(sc[g]), 8'(e.sc[g]));
                    chk($sformatf("%s lu_events%0d", e.nm, LL[g]),
                        8'(lu[g]), 8'(e.lu[g]));
                end
            end
        end
    end

    task automatic clr();
        for (int k = 0; k < NS; k++) begin
            irs[k] = '0;
            ers[k] = '0;
        end
        iused = '0; eused = '0;
        idrd = '0; mmrd = '0; wbrd = '0;
        mr = 1'b0; mw = 1'b0; ww = 1'b0;
    endtask

    task automatic cyc(input string nm, input bit cf,
                       input logic [5:0] fwx, input logic [2:0] sm,
                       input logic [2:0] stx, input logic [2:0] cm,
                       input cv_t scx, input cv_t lux);
        exp_t x;
        x.nm = nm; x.cf = cf; x.fw = fwx;
        x.sm = sm; x.st = stx; x.cm = cm;
        x.sc = scx; x.lu = lux;
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        clr();
        @(posedge clk);
        #1;
        // reset: fw live, stall forced low despite hazard
        ers[0] = 5; eused = 3'b001; mmrd = 5; mw = 1;
        mr = 1; idrd = 3; irs[1] = 3; iused = 3'b010;
        cyc("rst", 1, 6'b000010, 3'b111, 3'b000, 3'b111,
            {4'd0, 4'd0, 4'd0}, {4'd0, 4'd0, 4'd0});
        reset = 1'b0;
        clr();
        // forwarding
        ers[0] = 5; eused = 3'b001; mmrd = 5; mw = 1; wbrd = 5; ww = 1;
        cyc("fw_pri", 1, 6'b000010, 3'b111, 3'b000, 3'b111,
            {4'd0, 4'd0, 4'd0}, {4'd0, 4'd0, 4'd0});
        mw = 0;
        cyc("fw_wb", 1, 6'b000001, 3'b000, 3'b000, 3'b000, '0, '0);
        mw = 1; mmrd = 0; wbrd = 0;
        cyc("fw_x0", 1, 6'b000000, 3'b000, 3'b000, 3'b000, '0, '0);
        ers[1] = 7; mmrd = 7;
        cyc("fw_unused", 1, 6'b000000, 3'b000, 3'b000, 3'b000, '0, '0);
        eused = 3'b010;
        cyc("fw_p1", 1, 6'b001000, 3'b000, 3'b000, 3'b000, '0, '0);
        ers[2] = 9; eused = 3'b100; wbrd = 9;
        cyc("fw_p2wb", 1, 6'b010000, 3'b000, 3'b000, 3'b000, '0, '0);
        ers[2] = 7;
        cyc("fw_p2ex", 1, 6'b100000, 3'b000, 3'b000, 3'b000, '0, '0);
        clr();
        // load-use hazard
        mr = 1; idrd = 3; irs[1] = 3; iused = 3'b010;
        cyc("lu_det", 1, 6'b000000, 3'b111, 3'b111, 3'b111,
            {4'd0, 4'd0, 4'd0}, {4'd0, 4'd0, 4'd0});
        mr = 0;
        cyc("lu_c2", 0, '0, 3'b111, 3'b110, 3'b111,
            {4'd1, 4'd1, 4'd1}, {4'd1, 4'd1, 4'd1});
        cyc("lu_c3", 0, '0, 3'b111, 3'b110, 3'b111,
            {4'd2, 4'd2, 4'd1}, {4'd1, 4'd1, 4'd1});
        cyc("lu_c4", 0, '0, 3'b111, 3'b100, 3'b111,
            {4'd3, 4'd3, 4'd1}, {4'd1, 4'd1, 4'd1});
        cyc("lu_end", 0, '0, 3'b111, 3'b000, 3'b111,
            {4'd4, 4'd3, 4'd1}, {4'd1, 4'd1, 4'd1});
        // flush in second stall cycle
        mr = 1;
        cyc("fl_det", 0, '0, 3'b111, 3'b111, 3'b111,
            {4'd4, 4'd3, 4'd1}, {4'd1, 4'd1, 4'd1});
        mr = 0; flush = 1;
        cyc("fl_hold", 0, '0, 3'b111, 3'b000, 3'b111,
            {4'd5, 4'd4, 4'd2}, {4'd2, 4'd2, 4'd2});
        flush = 0;
        cyc("fl_after", 0, '0, 3'b111, 3'b000, 3'b111,
            {4'd5, 4'd4, 4'd2}, {4'd2, 4'd2, 4'd2});
        // flush in detection cycle
        mr = 1; flush = 1;
        cyc("fl_first", 0, '0, 3'b111, 3'b000, 3'b111,
            {4'd5, 4'd4, 4'd2}, {4'd2, 4'd2, 4'd2});
        mr = 0; flush = 0;
        cyc("fl_first2", 0, '0, 3'b111, 3'b000, 3'b111,
            {4'd5, 4'd4, 4'd2}, {4'd2, 4'd2, 4'd2});
        // 20 hazard cycles drive all counters toward saturation
        mr = 1;
        for (int i = 0; i < 20; i++) begin
            cyc("sat_run", 0, '0, 3'b001, 3'b001, 3'b000, '0, '0);
        end
        mr = 0;
        cyc("sat", 0, '0, 3'b111, 3'b010, 3'b111,
            {4'd15, 4'd15, 4'd15}, {4'd7, 4'd9, 4'd15});
        mr = 1;
        cyc("sat_hold", 0, '0, 3'b111, 3'b111, 3'b111,
            {4'd15, 4'd15, 4'd15}, {4'd7, 4'd9, 4'd15});
        // reset while the longer-latency instances are in HOLD
        mr = 0; reset = 1;
        cyc("rst_hold", 0, '0, 3'b111, 3'b000, 3'b111,
            {4'd15, 4'd15, 4'd15}, {4'd8, 4'd10, 4'd15});
        reset = 0;
        cyc("rst_after", 0, '0, 3'b111, 3'b000, 3'b111,
            {4'd0, 4'd0, 4'd0}, {4'd0, 4'd0, 4'd0});
        cyc("rst_idle", 0, '0, 3'b111, 3'b000, 3'b111,
            {4'd0, 4'd0, 4'd0}, {4'd0, 4'd0, 4'd0});
        repeat (2) @(negedge clk);
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d entries expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
